// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath.
// The controller (master) reads instruction fields and ALU flags and drives
// every datapath select/enable plus the sticky status outputs.
interface mips_mc_ctrl_if #(
    parameter int RET_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             OF;

    logic             PCWr;
    logic             IRWr;
    logic             MemWr;
    logic             RegWr;
    logic             IorD;
    logic [1:0]       RegDst;
    logic             MemtoReg;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUctr;
    logic             addi;
    logic [1:0]       ExtOp;
    logic [1:0]       PCSrc;

    logic             ovf;
    logic             illegal;
    logic [RET_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, OF,
        output PCWr, IRWr, MemWr, RegWr, IorD, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUctr, addi, ExtOp, PCSrc,
               ovf, illegal, retired
    );

    modport slave (
        output opcode, funct, zero, OF,
        input  PCWr, IRWr, MemWr, RegWr, IorD, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUctr, addi, ExtOp, PCSrc,
               ovf, illegal, retired
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXE/MEM/WB sequencing,
// Moore-decoded datapath controls, sticky ovf/illegal and a retire counter.
module mips_mc_ctrl #(
    parameter int RET_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_mc_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        st_fetch   = 4'd0,
        st_decode  = 4'd1,
        st_exe     = 4'd2,
        st_wb_alu  = 4'd3,
        st_mem_adr = 4'd4,
        st_mem_rd  = 4'd5,
        st_wb_lw   = 4'd6,
        st_mem_wr  = 4'd7,
        st_branch  = 4'd8,
        st_jump    = 4'd9,
        st_halt    = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t           state_reg, state_next;
    logic             ovf_q_reg;
    logic             ovf_reg;
    logic             illegal_reg;
    logic [RET_W-1:0] retired_reg;

    logic is_rtype, is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
    logic r_ok;
    logic set_illegal;
    logic retire;

    logic       pcwr_d, irwr_d, memwr_d, regwr_d, iord_d, memtoreg_d, alusrca_d, addi_d;
    logic [1:0] regdst_d, alusrcb_d, aluctr_d, extop_d, pcsrc_d;

    assign is_rtype = (bus.opcode == OP_RTYPE);
    assign is_addi  = (bus.opcode == OP_ADDI);
    assign is_ori   = (bus.opcode == OP_ORI);
    assign is_lui   = (bus.opcode == OP_LUI);
    assign is_lw    = (bus.opcode == OP_LW);
    assign is_sw    = (bus.opcode == OP_SW);
    assign is_beq   = (bus.opcode == OP_BEQ);
    assign is_j     = (bus.opcode == OP_J);
    assign r_ok     = is_rtype && ((bus.funct == FN_ADDU) || (bus.funct == FN_SUBU) ||
                                   (bus.funct == FN_SLT));

    // Instructions finish on these states; the counter steps on their edge.
    assign retire = (state_reg == st_wb_alu) || (state_reg == st_wb_lw) ||
                    (state_reg == st_mem_wr) || (state_reg == st_branch) ||
                    (state_reg == st_jump);

    // Next-state selection and Moore control decode (all controls default 0).
    always_comb begin
        state_next  = state_reg;
        set_illegal = 1'b0;
        pcwr_d      = 1'b0;
        irwr_d      = 1'b0;
        memwr_d     = 1'b0;
        regwr_d     = 1'b0;
        iord_d      = 1'b0;
        memtoreg_d  = 1'b0;
        alusrca_d   = 1'b0;
        addi_d      = 1'b0;
        regdst_d    = 2'b00;
        alusrcb_d   = 2'b00;
        aluctr_d    = 2'b00;
        extop_d     = 2'b00;
        pcsrc_d     = 2'b00;
        unique case (state_reg)
            st_fetch: begin
                irwr_d     = 1'b1;
                alusrcb_d  = 2'b01;
                pcwr_d     = 1'b1;
                state_next = st_decode;
            end
            st_decode: begin
                // Branch target PC+4+(imm<<2) is computed here speculatively.
                alusrcb_d = 2'b11;
                extop_d   = 2'b01;
                if (r_ok || is_addi || is_ori || is_lui) begin
                    state_next = st_exe;
                end else if (is_lw || is_sw) begin
                    state_next = st_mem_adr;
                end else if (is_beq) begin
                    state_next = st_branch;
                end else if (is_j) begin
                    state_next = st_jump;
                end else begin
                    state_next  = st_halt;
                    set_illegal = 1'b1;
                end
            end
            st_exe: begin
                alusrca_d = 1'b1;
                if (is_rtype) begin
                    alusrcb_d = 2'b00;
                    if (bus.funct == FN_SUBU)     aluctr_d = 2'b01;
                    else if (bus.funct == FN_SLT) aluctr_d = 2'b11;
                    else                          aluctr_d = 2'b00;
                end else if (is_addi) begin
                    alusrcb_d = 2'b10;
                    extop_d   = 2'b01;
                    addi_d    = 1'b1;
                end else if (is_ori) begin
                    // Immediate operand still comes through the extender.
                    alusrcb_d = 2'b10;
                    extop_d   = 2'b00;
                    aluctr_d  = 2'b10;
                end else begin
                    // lui: rs is $0, so OR with imm<<16 yields the result.
                    alusrcb_d = 2'b10;
                    extop_d   = 2'b10;
                    aluctr_d  = 2'b10;
                end
                state_next = st_wb_alu;
            end
            st_wb_alu: begin
                regdst_d   = is_rtype ? 2'b01 : 2'b00;
                regwr_d    = ~ovf_q_reg;
                state_next = st_fetch;
            end
            st_mem_adr: begin
                alusrca_d  = 1'b1;
                alusrcb_d  = 2'b10;
                extop_d    = 2'b01;
                state_next = is_lw ? st_mem_rd : st_mem_wr;
            end
            st_mem_rd: begin
                iord_d     = 1'b1;
                state_next = st_wb_lw;
            end
            st_wb_lw: begin
                memtoreg_d = 1'b1;
                regwr_d    = 1'b1;
                state_next = st_fetch;
            end
            st_mem_wr: begin
                iord_d     = 1'b1;
                memwr_d    = 1'b1;
                state_next = st_fetch;
            end
            st_branch: begin
                alusrca_d  = 1'b1;
                aluctr_d   = 2'b01;
                pcsrc_d    = 2'b01;
                pcwr_d     = bus.zero;
                state_next = st_fetch;
            end
            st_jump: begin
                pcsrc_d    = 2'b10;
                pcwr_d     = 1'b1;
                state_next = st_fetch;
            end
            st_halt: begin
                state_next = st_halt;
            end
            default: begin
                state_next = st_fetch;
            end
        endcase
    end

    // State register plus sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= st_fetch;
            ovf_q_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == st_exe) begin
                ovf_q_reg <= is_addi & bus.OF;
            end
            if ((state_reg == st_wb_alu) && ovf_q_reg) begin
                ovf_reg <= 1'b1;
            end
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (retire) begin
                retired_reg <= retired_reg + RET_W'(1);
            end
        end
    end

    // Everything is held at 0 while reset is asserted so no write can slip out.
    assign bus.PCWr     = rst_n & pcwr_d;
    assign bus.IRWr     = rst_n & irwr_d;
    assign bus.MemWr    = rst_n & memwr_d;
    assign bus.RegWr    = rst_n & regwr_d;
    assign bus.IorD     = rst_n & iord_d;
    assign bus.MemtoReg = rst_n & memtoreg_d;
    assign bus.ALUSrcA  = rst_n & alusrca_d;
    assign bus.addi     = rst_n & addi_d;
    assign bus.RegDst   = rst_n ? regdst_d  : 2'b00;
    assign bus.ALUSrcB  = rst_n ? alusrcb_d : 2'b00;
    assign bus.ALUctr   = rst_n ? aluctr_d  : 2'b00;
    assign bus.ExtOp    = rst_n ? extop_d   : 2'b00;
    assign bus.PCSrc    = rst_n ? pcsrc_d   : 2'b00;
    assign bus.ovf      = rst_n & ovf_reg;
    assign bus.illegal  = rst_n & illegal_reg;
    assign bus.retired  = rst_n ? retired_reg : '0;
endmodule
